// File: rtl/cpu_seg_display.sv
// Hex viewer for the multicycle CPU debug buses: latches one of four 16-bit words and
// scans it onto a 4-digit common-anode display. Define LEADING_ZERO_BLANK_EN to darken leading zeros.
module cpu_seg_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  sel,
    input  logic        load,
    input  logic [15:0] src0,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    input  logic [15:0] src3,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [1:0]  digit_idx
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [15:0]      shown;
    logic [15:0]      src_sel;
    logic             tick;
    logic [1:0]       next_idx;
    logic [3:0]       nibble;
    logic             blank;
    logic [7:0]       next_seg;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    always_comb begin
        src_sel = src0;
        case (sel)
            2'd0: src_sel = src0;
            2'd1: src_sel = src1;
            2'd2: src_sel = src2;
            default: src_sel = src3;
        endcase
    end

    // The digit decoded here is the one about to be lit, using the pre-capture shown value.
    always_comb begin
        tick     = (div == DIV_LAST);
        next_idx = digit_idx + 2'd1;
        nibble   = shown[{next_idx, 2'b00} +: 4];
        blank    = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (next_idx)
            2'd1: blank = (shown[15:4] == 12'h000);
            2'd2: blank = (shown[15:8] == 8'h00);
            2'd3: blank = (shown[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        next_seg = blank ? 8'hFF : hex_to_seg(nibble);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            div       <= '0;
            shown     <= 16'h0000;
            digit_idx <= 2'd0;
            an        <= 4'b1111;
            seg       <= 8'hFF;
        end else begin
            if (load)
                shown <= src_sel;
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                digit_idx <= next_idx;
                an        <= ~(4'b0001 << next_idx);
                seg       <= next_seg;
            end
        end
    end

endmodule
